// File: rtl/ixc_deposit_lt_if.sv
// Host deposit handshake plus design-side override bus for ixc_deposit_lt.
// The slave modport is the deposit block; the master modport is the host/harness side.
interface ixc_deposit_lt_if #(
  parameter int WIDTH  = 20,
  parameter int DEPTH  = 4,
  parameter int HOLD_W = 8
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic [HOLD_W-1:0] in_hold;
  logic              in_last;
  logic [WIDTH-1:0]  ov;
  logic              ov_en;
  logic              ov_apply;
  logic              seq_done;
  logic [LVL_W-1:0]  level;

  modport slave (
    input  in_valid, in_data, in_hold, in_last,
    output in_ready, ov, ov_en, ov_apply, seq_done, level
  );

  modport master (
    output in_valid, in_data, in_hold, in_last,
    input  in_ready, ov, ov_en, ov_apply, seq_done, level
  );
endinterface

// File: rtl/ixc_deposit_lt.sv
// Deposit-side counterpart of the sampleLT capture flops: buffers host words in a
// small FIFO and drives each onto ov (with ov_en) for hold+1 fclk cycles.
module ixc_deposit_lt #(
  parameter int WIDTH  = 20,
  parameter int DEPTH  = 4,
  parameter int HOLD_W = 8
) (
  input  logic             fclk,
  input  logic             rst_n,
  input  logic             flush,
  ixc_deposit_lt_if.slave  dep
);
  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  typedef struct packed {
    logic              last;
    logic [HOLD_W-1:0] hold;
    logic [WIDTH-1:0]  data;
  } entry_t;

  typedef enum logic {S_IDLE, S_DRIVE} state_t;

  entry_t             r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [LVL_W-1:0]   r_level;

  state_t             r_state;
  logic [HOLD_W-1:0]  r_cnt;
  logic               r_cur_last;
  logic [WIDTH-1:0]   r_ov;
  logic               r_ov_en;
  logic               r_ov_apply;
  logic               r_seq_done;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_slot_free;
  entry_t             w_in_entry;
  entry_t             w_head;

  assign w_full      = (r_level == LVL_W'(DEPTH));
  assign w_empty     = (r_level == '0);
  assign w_push      = dep.in_valid && !w_full && !flush;
  // A new entry may be taken when idle or when the current one is in its last cycle.
  assign w_slot_free = (r_state == S_IDLE) || (r_cnt == '0);
  assign w_pop       = w_slot_free && !w_empty && !flush;
  assign w_in_entry  = '{last: dep.in_last, hold: dep.in_hold, data: dep.in_data};
  assign w_head      = r_mem[r_rd_ptr];

  // NOTE: the storage array is not reset; pointers and level alone define which entries are valid.
  always_ff @(posedge fclk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_in_entry;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_cur_last <= 1'b0;
      r_ov       <= '0;
      r_ov_en    <= 1'b0;
      r_ov_apply <= 1'b0;
      r_seq_done <= 1'b0;
    end else begin
      r_ov_apply <= 1'b0;
      r_seq_done <= 1'b0;
      if (flush) begin
        // ov deliberately keeps its value; only the enable is dropped.
        r_state    <= S_IDLE;
        r_cnt      <= '0;
        r_cur_last <= 1'b0;
        r_ov_en    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_pop) begin
              r_ov       <= w_head.data;
              r_cnt      <= w_head.hold;
              r_cur_last <= w_head.last;
              r_ov_en    <= 1'b1;
              r_ov_apply <= 1'b1;
              r_state    <= S_DRIVE;
            end
          end
          S_DRIVE: begin
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - HOLD_W'(1);
            end else begin
              r_seq_done <= r_cur_last;
              if (w_pop) begin
                r_ov       <= w_head.data;
                r_cnt      <= w_head.hold;
                r_cur_last <= w_head.last;
                r_ov_apply <= 1'b1;
              end else begin
                r_ov_en    <= 1'b0;
                r_cur_last <= 1'b0;
                r_state    <= S_IDLE;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign dep.in_ready = !w_full;
  assign dep.ov       = r_ov;
  assign dep.ov_en    = r_ov_en;
  assign dep.ov_apply = r_ov_apply;
  assign dep.seq_done = r_seq_done;
  assign dep.level    = r_level;
endmodule

// File: tb/tb_ixc_deposit_lt.sv
// Scoreboard bench for ixc_deposit_lt: stimulus queues expected entries, a negedge
// monitor pops them on each ov_apply and checks value, duration and seq_done.
module tb_ixc_deposit_lt;
  logic fclk;
  logic rst_n;
  logic flush;

  ixc_deposit_lt_if dif ();

  ixc_deposit_lt dut (
    .fclk  (fclk),
    .rst_n (rst_n),
    .flush (flush),
    .dep   (dif)
  );

  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  typedef struct {
    logic [19:0] data;
    logic [7:0]  hold;
    logic        last;
  } exp_t;

  exp_t        exp_q [$];
  exp_t        cur;
  bit          active;
  int          rem;
  bit          pend_flush;
  logic [19:0] flush_ov;
  int          en_cycles;
  int          apply_cnt;
  int          done_cnt;
  int          n_checks;
  int          n_errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_counts();
    en_cycles = 0;
    apply_cnt = 0;
    done_cnt  = 0;
  endtask

  // Monitor: each ov_apply must match the oldest expected entry, which then
  // occupies exactly hold+1 samples before seq_done/ov_en reflect its end.
  always @(negedge fclk) begin
    if (!rst_n) begin
      exp_q.delete();
      active     = 0;
      pend_flush = 0;
    end else if (pend_flush) begin
      check("flush_ov_en",    {31'd0, dif.ov_en},    32'd0);
      check("flush_level",    {29'd0, dif.level},    32'd0);
      check("flush_ov_hold",  {12'd0, dif.ov},       {12'd0, flush_ov});
      check("flush_apply",    {31'd0, dif.ov_apply}, 32'd0);
      check("flush_seq_done", {31'd0, dif.seq_done}, 32'd0);
      pend_flush = 0;
    end else begin
      if (dif.ov_en)    en_cycles++;
      if (dif.ov_apply) apply_cnt++;
      if (dif.seq_done) done_cnt++;
      if (active) begin
        if (rem == 0) begin
          check("seq_done", {31'd0, dif.seq_done}, {31'd0, cur.last});
          check("entry_end", {31'd0, (dif.ov_apply || !dif.ov_en)}, 32'd1);
          active = 0;
        end else begin
          rem--;
          check("hold_ov", {12'd0, dif.ov}, {12'd0, cur.data});
          check("hold_en", {31'd0, dif.ov_en}, 32'd1);
          check("mid_apply", {31'd0, dif.ov_apply}, 32'd0);
        end
      end else if (dif.seq_done) begin
        check("stray_seq_done", {31'd0, dif.seq_done}, 32'd0);
      end
      if (dif.ov_apply) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_apply: got ov=0x%0h with empty scoreboard at %0t", dif.ov, $time);
        end else begin
          cur = exp_q.pop_front();
          check("apply_ov", {12'd0, dif.ov}, {12'd0, cur.data});
          check("apply_en", {31'd0, dif.ov_en}, 32'd1);
          rem    = int'(cur.hold);
          active = 1;
        end
      end
      if (flush) begin
        exp_q.delete();
        active     = 0;
        pend_flush = 1;
        flush_ov   = dif.ov;
      end
    end
  end

  // Presents one word and waits until it is accepted; queues its expectation.
  task automatic push(input logic [19:0] data, input logic [7:0] hold, input logic last);
    int  guard;
    exp_t e;
    guard = 0;
    dif.in_valid = 1'b1;
    dif.in_data  = data;
    dif.in_hold  = hold;
    dif.in_last  = last;
    forever begin
      @(negedge fclk);
      if (dif.in_ready) break;
      guard++;
      if (guard > 2000) break;
    end
    if (guard > 2000) begin
      n_checks++;
      n_errors++;
      $display("FAIL push_timeout: in_ready stuck low for data 0x%0h", data);
    end else begin
      @(posedge fclk);
      e.data = data;
      e.hold = hold;
      e.last = last;
      exp_q.push_back(e);
    end
    #1;
    dif.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge fclk);
      #1;
      if (exp_q.size() == 0 && !active && !dif.ov_en) begin
        done = 1;
        break;
      end
    end
    check(name, {31'd0, done}, 32'd1);
    @(posedge fclk);
    #1;
  endtask

  task automatic single_word_case(input string tag);
    clear_counts();
    push(20'hABCDE, 8'd0, 1'b0);
    @(negedge fclk);
    check({tag, "_not_early"}, {31'd0, dif.ov_apply}, 32'd0);
    @(negedge fclk);
    check({tag, "_ov"},    {12'd0, dif.ov},       32'h000ABCDE);
    check({tag, "_en"},    {31'd0, dif.ov_en},    32'd1);
    check({tag, "_apply"}, {31'd0, dif.ov_apply}, 32'd1);
    @(negedge fclk);
    check({tag, "_en_drop"}, {31'd0, dif.ov_en}, 32'd0);
    check({tag, "_ov_keep"}, {12'd0, dif.ov},    32'h000ABCDE);
    wait_idle({tag, "_idle"}, 20);
    check({tag, "_en_cycles"}, en_cycles, 32'd1);
    check({tag, "_apply_cnt"}, apply_cnt, 32'd1);
    check({tag, "_done_cnt"},  done_cnt,  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    active       = 0;
    pend_flush   = 0;
    rem          = 0;
    flush_ov     = '0;
    rst_n        = 1'b0;
    flush        = 1'b0;
    dif.in_valid = 1'b0;
    dif.in_data  = '0;
    dif.in_hold  = '0;
    dif.in_last  = 1'b0;
    clear_counts();

    #23;
    check("rst_ov",       {12'd0, dif.ov},       32'd0);
    check("rst_ov_en",    {31'd0, dif.ov_en},    32'd0);
    check("rst_apply",    {31'd0, dif.ov_apply}, 32'd0);
    check("rst_seq_done", {31'd0, dif.seq_done}, 32'd0);
    check("rst_level",    {29'd0, dif.level},    32'd0);
    check("rst_in_ready", {31'd0, dif.in_ready}, 32'd1);
    @(negedge fclk);
    rst_n = 1'b1;
    @(posedge fclk);
    #1;

    // Single word, hold=0.
    single_word_case("s1");

    // Three words back to back, holds 2,0,1, last on the third.
    clear_counts();
    push(20'h11111, 8'd2, 1'b0);
    push(20'h22222, 8'd0, 1'b0);
    push(20'h33333, 8'd1, 1'b1);
    wait_idle("s2_idle", 50);
    check("s2_en_cycles", en_cycles, 32'd6);
    check("s2_apply_cnt", apply_cnt, 32'd3);
    check("s2_done_cnt",  done_cnt,  32'd1);

    // Fill to full, then keep pushing across pointer wrap.
    clear_counts();
    for (int i = 0; i < 5; i++) push(20'h40000 + 20'(i), 8'd10, 1'b0);
    @(negedge fclk);
    check("s3_level_full", {29'd0, dif.level},    32'd4);
    check("s3_in_ready",   {31'd0, dif.in_ready}, 32'd0);
    @(posedge fclk);
    #1;
    for (int i = 5; i < 8; i++) push(20'h40000 + 20'(i), 8'd10, (i == 7));
    wait_idle("s3_idle", 200);
    check("s3_apply_cnt", apply_cnt, 32'd8);
    check("s3_en_cycles", en_cycles, 32'd88);
    check("s3_done_cnt",  done_cnt,  32'd1);

    // Flush while driving with two words queued and a concurrent push.
    push(20'h4A4A4, 8'd20, 1'b0);
    push(20'h4B4B4, 8'd0, 1'b0);
    push(20'h4C4C4, 8'd0, 1'b1);
    repeat (2) begin
      @(posedge fclk);
      #1;
    end
    clear_counts();
    flush        = 1'b1;
    dif.in_valid = 1'b1;
    dif.in_data  = 20'h4DDDD;
    dif.in_hold  = 8'd0;
    dif.in_last  = 1'b1;
    @(posedge fclk);
    #1;
    flush        = 1'b0;
    dif.in_valid = 1'b0;
    @(negedge fclk);
    check("s4_ov_en", {31'd0, dif.ov_en}, 32'd0);
    check("s4_level", {29'd0, dif.level}, 32'd0);
    check("s4_ov",    {12'd0, dif.ov},    32'h0004A4A4);
    repeat (5) @(negedge fclk);
    check("s4_level_after", {29'd0, dif.level}, 32'd0);
    check("s4_apply_after", apply_cnt,          32'd0);
    check("s4_done_after",  done_cnt,           32'd0);
    @(posedge fclk);
    #1;

    // Asynchronous reset in the middle of a long entry.
    push(20'h55555, 8'd30, 1'b1);
    repeat (5) @(posedge fclk);
    #3;
    rst_n = 1'b0;
    #1;
    check("s5_ov",       {12'd0, dif.ov},       32'd0);
    check("s5_ov_en",    {31'd0, dif.ov_en},    32'd0);
    check("s5_apply",    {31'd0, dif.ov_apply}, 32'd0);
    check("s5_seq_done", {31'd0, dif.seq_done}, 32'd0);
    check("s5_level",    {29'd0, dif.level},    32'd0);
    check("s5_in_ready", {31'd0, dif.in_ready}, 32'd1);
    repeat (2) @(posedge fclk);
    #3;
    rst_n = 1'b1;
    @(posedge fclk);
    #1;
    single_word_case("s5r");

    // Maximum hold: 256 cycles.
    clear_counts();
    push(20'h66666, 8'hFF, 1'b1);
    wait_idle("s6_idle", 400);
    check("s6_en_cycles", en_cycles, 32'd256);
    check("s6_apply_cnt", apply_cnt, 32'd1);
    check("s6_done_cnt",  done_cnt,  32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
